// File: rtl/snoop_bus_arb.sv
// Snooping coherence bus: round-robin arbitration of rd/wr/upg misses, snoop, forward or fetch, invalidate.
// Latency request->done: rd hit 3+HOLD, rd miss 3+MEM_LAT, wr one more, upg 3 cycles.
// Backpressure: requesters hold their request until done; the bus serves one transaction at a time.
module snoop_bus_arb #(
    parameter int NCPU    = 4,
    parameter int ADDR_W  = 11,
    parameter int HOLD    = 2,
    parameter int MEM_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCPU-1:0]          req_rd,
    input  logic [NCPU-1:0]          req_wr,
    input  logic [NCPU-1:0]          req_upg,
    input  logic [NCPU*ADDR_W-1:0]   req_addr,
    input  logic [NCPU-1:0]          snoop_hit,
    input  logic [NCPU-1:0]          snoop_dirty,
    output logic [NCPU-1:0]          grant,
    output logic [NCPU-1:0]          done,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [NCPU-1:0]          snoop_req,
    output logic [NCPU-1:0]          fwd_sel,
    output logic [$clog2(NCPU)-1:0]  src_id,
    output logic [NCPU-1:0]          inval,
    output logic [NCPU-1:0]          wback_dmem,
    output logic                     mem_rd
);
    localparam int IDW  = $clog2(NCPU);
    localparam int MAXC = (HOLD > MEM_LAT) ? HOLD : MEM_LAT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_FWD, S_MEM, S_INVAL, S_DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_UPG} op_t;

    state_t            state;
    op_t               op_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    rr_q;
    logic [IDW-1:0]    src_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     cnt_q;

    logic [NCPU-1:0]   pend;
    logic              win_vld;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    idx;
    op_t               win_op;
    logic [ADDR_W-1:0] win_addr;
    logic [NCPU-1:0]   owner_oh;
    logic [NCPU-1:0]   hit_m;
    logic [NCPU-1:0]   dirty_m;
    logic [IDW-1:0]    hit_idx;

    assign pend     = req_rd | req_wr | req_upg;
    assign owner_oh = NCPU'(1) << id_q;
    assign hit_m    = snoop_hit & ~owner_oh;
    assign dirty_m  = snoop_dirty & ~owner_oh;

    // Round-robin search starting at rr_q, wrapping past NCPU-1.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        idx      = '0;
        for (int i = 0; i < NCPU; i++) begin
            idx = IDW'((int'(rr_q) + i) % NCPU);
            if (!win_vld && pend[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
        win_op   = req_rd[win_id] ? OP_RD : (req_wr[win_id] ? OP_WR : OP_UPG);
        win_addr = req_addr[win_id*ADDR_W +: ADDR_W];
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            if (hit_m[i]) hit_idx = IDW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_RD;
            id_q   <= '0;
            rr_q   <= '0;
            src_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (win_vld) begin
                        id_q   <= win_id;
                        op_q   <= win_op;
                        addr_q <= win_addr;
                        state  <= (win_op == OP_UPG) ? S_INVAL : S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    src_q <= hit_idx;
                    cnt_q <= '0;
                    state <= (|hit_m) ? S_FWD : S_MEM;
                end
                S_FWD: begin
                    if (cnt_q == CW'(HOLD - 1)) begin
                        cnt_q <= '0;
                        state <= (op_q == OP_RD) ? S_DONE : S_INVAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MEM: begin
                    if (cnt_q == CW'(MEM_LAT - 1)) begin
                        cnt_q <= '0;
                        state <= (op_q == OP_RD) ? S_DONE : S_INVAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_INVAL: state <= S_DONE;
                S_DONE: begin
                    rr_q  <= IDW'((int'(id_q) + 1) % NCPU);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Dirty peer supplies data and pushes its copy to dmem in the snoop cycle.
    always_comb begin
        grant      = '0;
        done       = '0;
        bus_addr   = '0;
        snoop_req  = '0;
        fwd_sel    = '0;
        src_id     = '0;
        inval      = '0;
        wback_dmem = '0;
        mem_rd     = 1'b0;
        if (state != S_IDLE) begin
            grant    = owner_oh;
            bus_addr = addr_q;
        end
        case (state)
            S_SNOOP: begin
                snoop_req = ~owner_oh;
                src_id    = hit_idx;
                if (|hit_m && dirty_m[hit_idx]) wback_dmem = NCPU'(1) << hit_idx;
            end
            S_FWD: begin
                fwd_sel = owner_oh;
                src_id  = src_q;
            end
            S_MEM:   mem_rd = 1'b1;
            S_INVAL: begin
                inval      = ~owner_oh;
                wback_dmem = owner_oh;
            end
            S_DONE:  done = owner_oh;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_snoop_bus_arb.sv
// Self-checking bench for snoop_bus_arb: scenario tasks plus a done/bus_addr scoreboard.
module tb_snoop_bus_arb;
    localparam int NCPU = 4;
    localparam int AW   = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCPU-1:0] req_rd = '0, req_wr = '0, req_upg = '0;
    logic [NCPU*AW-1:0] req_addr = '0;
    logic [NCPU-1:0] snoop_hit = '0, snoop_dirty = '0;
    logic [NCPU-1:0] grant, done, snoop_req, fwd_sel, inval, wback_dmem;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      src_id;
    logic            mem_rd;

    snoop_bus_arb #(.NCPU(NCPU), .ADDR_W(AW), .HOLD(2), .MEM_LAT(4)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_upg(req_upg),
        .req_addr(req_addr), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .grant(grant), .done(done), .bus_addr(bus_addr), .snoop_req(snoop_req),
        .fwd_sel(fwd_sel), .src_id(src_id), .inval(inval), .wback_dmem(wback_dmem),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [NCPU-1:0] done_v;
        logic [AW-1:0]   addr;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Scoreboard: every done pulse must match the oldest expected owner/address.
    always @(negedge clk) begin
        if (!rst && done !== '0) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_done got done=%b", done);
            end else begin
                mon_e = sb_q.pop_front();
                if (done !== mon_e.done_v || bus_addr !== mon_e.addr) begin
                    tests_failed++;
                    $display("FAIL sb_done got done=%b addr=%h exp done=%b addr=%h",
                             done, bus_addr, mon_e.done_v, mon_e.addr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Per-transaction observations collected by observe()
    logic [NCPU-1:0] first_grant, snoop_obs, fwd_val, inval_obs, wb_snoop, wb_inval, done_obs;
    logic [1:0]      src_obs;
    int fwd_n, mem_n, inval_n, inval_cyc, done_lat;

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Cycle n = state after the n-th rising edge following the request; the requester
    // samples done at edge n+1, which is the latency figure recorded in done_lat.
    task automatic observe(input int budget);
        first_grant = '0; snoop_obs = '0; fwd_val = '0; inval_obs = '0;
        wb_snoop = '0; wb_inval = '0; done_obs = '0; src_obs = '0;
        fwd_n = 0; mem_n = 0; inval_n = 0; inval_cyc = 0; done_lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (n == 1) first_grant = grant;
            if (snoop_req != '0) begin snoop_obs = snoop_req; wb_snoop = wback_dmem; end
            if (fwd_sel != '0) begin fwd_n++; fwd_val = fwd_sel; src_obs = src_id; end
            if (mem_rd) mem_n++;
            if (inval != '0) begin
                inval_n++; inval_obs = inval; wb_inval = wback_dmem;
                if (inval_cyc == 0) inval_cyc = n;
            end
            if (done != '0) begin done_obs = done; done_lat = n + 1; break; end
        end
        if (done_lat == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL observe_timeout no done within %0d cycles", budget);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({grant, done, snoop_req, fwd_sel, inval, wback_dmem, mem_rd, src_id} !== '0) begin
            tests_failed++; $display("FAIL reset_outputs got nonzero outputs grant=%b done=%b", grant, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (grant !== '0 || bus_addr !== '0) begin
            tests_failed++; $display("FAIL idle_no_req got grant=%b addr=%h exp 0 0", grant, bus_addr);
        end
    endtask

    task automatic test_rd_hit();
        req_rd[2] = 1'b1; set_addr(2, 11'h155); snoop_hit = 4'b0101; snoop_dirty = '0;
        sb_q.push_back('{4'b0100, 11'h155});
        observe(30);
        req_rd = '0; snoop_hit = '0;
        tests_run++; if (first_grant !== 4'b0100) begin tests_failed++; $display("FAIL rdhit_grant got %b exp 0100", first_grant); end
        tests_run++; if (snoop_obs !== 4'b1011) begin tests_failed++; $display("FAIL rdhit_snoop_req got %b exp 1011", snoop_obs); end
        tests_run++; if (src_obs !== 2'd0) begin tests_failed++; $display("FAIL rdhit_src got %0d exp 0", src_obs); end
        tests_run++; if (fwd_n != 2 || fwd_val !== 4'b0100) begin tests_failed++; $display("FAIL rdhit_fwd got %0d cyc %b exp 2 cyc 0100", fwd_n, fwd_val); end
        tests_run++; if (inval_n != 0 || mem_n != 0 || wb_snoop !== '0) begin tests_failed++; $display("FAIL rdhit_side got inval %0d mem %0d wb %b exp 0 0 0", inval_n, mem_n, wb_snoop); end
        tests_run++; if (done_lat != 5) begin tests_failed++; $display("FAIL rdhit_latency got %0d exp 5", done_lat); end
    endtask

    task automatic test_reset_mid_fwd();
        int seen;
        seen = 0;
        req_rd[2] = 1'b1; set_addr(2, 11'h155); snoop_hit = 4'b0001;
        for (int n = 0; n < 10 && seen == 0; n++) begin
            @(posedge clk); #1;
            if (fwd_sel != '0) seen = 1;
        end
        tests_run++; if (seen == 0) begin tests_failed++; $display("FAIL midfwd_reach got no fwd exp fwd"); end
        rst = 1'b1; #1;
        req_rd = '0; snoop_hit = '0;
        @(posedge clk); #1;
        tests_run++;
        if (grant !== '0 || fwd_sel !== '0 || done !== '0) begin
            tests_failed++; $display("FAIL midfwd_reset got grant=%b fwd=%b done=%b exp 0", grant, fwd_sel, done);
        end
        rst = 1'b0;
        req_rd = 4'b1001; set_addr(0, 11'h011); set_addr(3, 11'h733);
        sb_q.push_back('{4'b0001, 11'h011});
        observe(30);
        req_rd[0] = 1'b0;
        tests_run++; if (first_grant !== 4'b0001) begin tests_failed++; $display("FAIL midfwd_first_grant got %b exp 0001", first_grant); end
        sb_q.push_back('{4'b1000, 11'h733});
        observe(30);
        req_rd[3] = 1'b0;
        tests_run++; if (done_obs !== 4'b1000 || done_lat != 7) begin tests_failed++; $display("FAIL midfwd_second got %b lat %0d exp 1000 lat 7", done_obs, done_lat); end
    endtask

    task automatic test_wr_miss();
        req_wr[1] = 1'b1; set_addr(1, 11'h0A0);
        sb_q.push_back('{4'b0010, 11'h0A0});
        observe(30);
        req_wr = '0;
        tests_run++; if (snoop_obs !== 4'b1101) begin tests_failed++; $display("FAIL wr_snoop_req got %b exp 1101", snoop_obs); end
        tests_run++; if (mem_n != 4 || fwd_n != 0) begin tests_failed++; $display("FAIL wr_mem got mem %0d fwd %0d exp 4 0", mem_n, fwd_n); end
        tests_run++; if (inval_n != 1 || inval_obs !== 4'b1101) begin tests_failed++; $display("FAIL wr_inval got %0d %b exp 1 1101", inval_n, inval_obs); end
        tests_run++; if (wb_inval !== 4'b0010) begin tests_failed++; $display("FAIL wr_wback got %b exp 0010", wb_inval); end
        tests_run++; if (done_lat != 8) begin tests_failed++; $display("FAIL wr_latency got %0d exp 8", done_lat); end
    endtask

    task automatic test_rd_dirty();
        req_rd[3] = 1'b1; set_addr(3, 11'h3C3); snoop_hit = 4'b1010; snoop_dirty = 4'b1010;
        sb_q.push_back('{4'b1000, 11'h3C3});
        observe(30);
        req_rd = '0; snoop_hit = '0; snoop_dirty = '0;
        tests_run++; if (wb_snoop !== 4'b0010) begin tests_failed++; $display("FAIL dirty_wback got %b exp 0010", wb_snoop); end
        tests_run++; if (src_obs !== 2'd1 || fwd_val !== 4'b1000 || fwd_n != 2) begin tests_failed++; $display("FAIL dirty_fwd got src %0d sel %b n %0d exp 1 1000 2", src_obs, fwd_val, fwd_n); end
        tests_run++; if (inval_n != 0 || done_lat != 5) begin tests_failed++; $display("FAIL dirty_tail got inval %0d lat %0d exp 0 5", inval_n, done_lat); end
    endtask

    task automatic test_rd_upg();
        req_rd[0] = 1'b1; req_upg[0] = 1'b1; set_addr(0, 11'h2AA);
        snoop_hit = 4'b0001; snoop_dirty = 4'b0001;
        sb_q.push_back('{4'b0001, 11'h2AA});
        observe(30);
        req_rd[0] = 1'b0;
        tests_run++; if (mem_n != 4 || fwd_n != 0 || wb_snoop !== '0) begin tests_failed++; $display("FAIL rdupg_rd_first got mem %0d fwd %0d wb %b exp 4 0 0", mem_n, fwd_n, wb_snoop); end
        tests_run++; if (inval_n != 0 || done_lat != 7) begin tests_failed++; $display("FAIL rdupg_rd_tail got inval %0d lat %0d exp 0 7", inval_n, done_lat); end
        sb_q.push_back('{4'b0001, 11'h2AA});
        observe(30);
        req_upg = '0; snoop_hit = '0; snoop_dirty = '0;
        tests_run++; if (inval_cyc != 1 || inval_obs !== 4'b1110) begin tests_failed++; $display("FAIL upg_inval got cyc %0d %b exp 1 1110", inval_cyc, inval_obs); end
        tests_run++; if (wb_inval !== 4'b0001 || snoop_obs !== '0 || mem_n != 0) begin tests_failed++; $display("FAIL upg_side got wb %b snoop %b mem %0d exp 0001 0 0", wb_inval, snoop_obs, mem_n); end
        tests_run++; if (done_lat != 3) begin tests_failed++; $display("FAIL upg_latency got %0d exp 3", done_lat); end
    endtask

    task automatic test_back_to_back();
        logic [NCPU-1:0] seq [5];
        logic [NCPU-1:0] exp_seq [5];
        int k;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < NCPU; i++) set_addr(i, AW'(11'h100 + i));
        for (int i = 0; i < 5; i++) sb_q.push_back('{exp_seq[i], AW'(11'h100 + (i % NCPU))});
        req_rd = 4'b1111;
        k = 0;
        for (int n = 0; n < 120 && k < 5; n++) begin
            @(posedge clk); #1;
            if (done != '0) begin seq[k] = done; k++; end
        end
        @(posedge clk); #1;
        req_rd = '0;
        tests_run++; if (k != 5) begin tests_failed++; $display("FAIL rr_count got %0d dones exp 5", k); end
        for (int i = 0; i < k; i++) begin
            tests_run++;
            if (seq[i] !== exp_seq[i]) begin tests_failed++; $display("FAIL rr_order[%0d] got %b exp %b", i, seq[i], exp_seq[i]); end
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (grant !== '0) begin tests_failed++; $display("FAIL rr_idle got grant %b exp 0", grant); end
    endtask

    initial begin
        test_reset();
        test_rd_hit();
        test_reset_mid_fwd();
        test_wr_miss();
        test_rd_dirty();
        test_rd_upg();
        test_back_to_back();
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover got %0d pending exp 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
